// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned BE_W = 4;
  localparam logic [BE_W-1:0] BE_FULL = 4'hF;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating counter of consecutive data grants; flags when the fetch side is owed a slot.
module arb_streak_counter #(
  parameter int unsigned MAX_VAL = 4,
  parameter int unsigned CW      = $clog2(MAX_VAL + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CW'(MAX_VAL))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max_o = (count_q == CW'(MAX_VAL));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: data first, bounded data streaks,
// one outstanding transaction, flushed fetch responses are swallowed.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned xlen        = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [xlen-1:0] i_addr,
  input  logic            i_flush,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [xlen-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [BE_W-1:0] d_be,
  input  logic [xlen-1:0] d_addr,
  input  logic [xlen-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [xlen-1:0] d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [BE_W-1:0] m_be,
  output logic [xlen-1:0] m_addr,
  output logic [xlen-1:0] m_wdata,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [xlen-1:0] m_rdata
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  arb_owner_t lock_sel_q, lock_sel_d;
  logic       lock_q, lock_d;
  logic       kill_q, kill_d;

  arb_owner_t sel_c;
  logic       lock_flush_c;
  logic       streak_max_c;
  logic       streak_inc_c;
  logic       streak_clr_c;

  // Requester selection while idle; a flushed locked fetch is abandoned outright.
  always_comb begin
    sel_c        = OWN_NONE;
    lock_flush_c = lock_q && (lock_sel_q == OWN_I) && i_flush;
    if (lock_q) begin
      sel_c = lock_sel_q;
    end else if (i_req && !i_flush && (!d_req || streak_max_c)) begin
      sel_c = OWN_I;
    end else if (d_req) begin
      sel_c = OWN_D;
    end
    if (lock_flush_c) begin
      sel_c = OWN_NONE;
    end
  end

  // Memory-side request mux and zero-latency grant pass-through.
  always_comb begin
    m_req   = !rst && (state_q == IDLE) && (sel_c != OWN_NONE);
    m_addr  = d_addr;
    m_we    = 1'b0;
    m_be    = BE_FULL;
    m_wdata = '0;
    if (sel_c == OWN_I) begin
      m_addr = i_addr;
    end else if (sel_c == OWN_D) begin
      m_we    = d_we;
      m_be    = d_be;
      m_wdata = d_wdata;
    end
    i_gnt = m_req && m_gnt && (sel_c == OWN_I);
    d_gnt = m_req && m_gnt && (sel_c == OWN_D);
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    kill_d     = kill_q;
    case (state_q)
      IDLE: begin
        if (lock_flush_c) begin
          lock_d = 1'b0;
        end else if (m_req) begin
          if (m_gnt) begin
            owner_d = sel_c;
            lock_d  = 1'b0;
            kill_d  = (sel_c == OWN_I) && i_flush;
            state_d = WAIT_RESP;
          end else begin
            lock_d     = 1'b1;
            lock_sel_d = sel_c;
          end
        end
      end
      WAIT_RESP: begin
        if ((owner_q == OWN_I) && i_flush) begin
          kill_d = 1'b1;
        end
        if (m_rvalid) begin
          owner_d = OWN_NONE;
          kill_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      lock_q     <= 1'b0;
      lock_sel_q <= OWN_NONE;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      kill_q     <= kill_d;
    end
  end

  // Streak only grows while a fetch is actually waiting behind data.
  assign streak_inc_c = d_gnt && i_req;
  assign streak_clr_c = i_gnt || (d_gnt && !i_req);

  arb_streak_counter #(
    .MAX_VAL (MAX_DSTREAK)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (streak_inc_c),
    .clr_i    (streak_clr_c),
    .at_max_o (streak_max_c)
  );

  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign i_rvalid = m_rvalid && (owner_q == OWN_I) && !kill_q && !i_flush;
  assign d_rvalid = m_rvalid && (owner_q == OWN_D);

`ifndef SYNTHESIS
  a_no_rvalid_in_idle : assert property (@(posedge clk) disable iff (rst)
    !((state_q == IDLE) && m_rvalid));
  a_dreq_held_when_locked : assert property (@(posedge clk) disable iff (rst)
    (lock_q && (lock_sel_q == OWN_D)) |-> d_req);
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between the instruction fetch path and the load/store unit.
- Data accesses have priority; a bounded-streak counter guarantees fetch progress.
- One transaction is outstanding at a time, using a req/gnt/rvalid handshake on each side.
- Honours the fetch-side flush: an in-flight instruction response is consumed but never forwarded.

Parameters:
- xlen, 32, address/data width.
- MAX_DSTREAK, 4, max consecutive data grants while an instruction request waits (>=1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- i_req  in  1  fetch request
- i_addr  in  xlen  fetch address
- i_flush  in  1  fetch flush/redirect
- i_gnt  out  1  fetch request accepted
- i_rvalid  out  1  fetch response valid
- i_rdata  out  xlen  fetch response data
- d_req  in  1  load/store request
- d_we  in  1  write enable
- d_be  in  4  byte enables
- d_addr  in  xlen  data address
- d_wdata  in  xlen  write data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  data response valid (reads and writes)
- d_rdata  out  xlen  read data
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_be  out  4  memory byte enables
- m_addr  out  xlen  memory address
- m_wdata  out  xlen  memory write data
- m_gnt  in  1  memory accepted request
- m_rvalid  in  1  memory response valid
- m_rdata  in  xlen  memory read data

Behaviour:
- Reset (async, rst=1):
  - State IDLE, owner=NONE, lock=0, kill=0, d_streak=0.
  - m_req, i_gnt, d_gnt, i_rvalid and d_rvalid all 0.
- FSM states: IDLE and WAIT_RESP.
- IDLE selection (combinational):
  - If lock=1, keep the locked requester.
  - Else if the instruction request is eligible (i_req & !i_flush) and either d_req=0 or d_streak==MAX_DSTREAK, select I.
  - Else if d_req, select D.
  - Else select none.
- IDLE drive:
  - m_req = 1 when a requester is selected; m_addr/m_we/m_be/m_wdata are muxed from the selection.
  - For I: m_we=0, m_be=4'hF, m_wdata=0.
  - i_gnt = m_gnt & sel==I; d_gnt = m_gnt & sel==D. Both are combinational pass-through (0-cycle).
- IDLE, m_req=1 and m_gnt=0: set lock=1 (selection held until granted; requesters must hold req).
- Locked fetch flushed: if lock=1, sel==I and i_flush=1, drop m_req that cycle and clear lock. The request is abandoned because the memory holds no state before gnt.
- IDLE, m_gnt=1: capture owner, clear lock, go to WAIT_RESP.
  - If owner=I and i_flush is high in the same cycle, set kill=1.
- d_streak update on each grant:
  - D grant while i_req=1: saturating +1.
  - I grant: cleared to 0.
  - D grant with i_req=0: cleared to 0.
- WAIT_RESP:
  - m_req=0; i_gnt and d_gnt are 0; new requests stall.
  - i_flush while owner=I sets kill=1.
- Response routing: i_rdata/d_rdata = m_rdata always.
  - i_rvalid = m_rvalid & owner==I & !kill & !i_flush.
  - d_rvalid = m_rvalid & owner==D.
  - On m_rvalid: go to IDLE, clear owner and kill.
- Throughput: the earliest next m_req is the cycle after rvalid, so 1 idle bubble.
- Boundary cases:
  - m_rvalid in IDLE: ignored; a simulation assertion flags it.
  - d_req changing while locked on D: protocol violation, asserted.
  - Flush with no instruction transaction in flight: no effect on data traffic.
  - rst mid-transaction: everything returns to reset values and the outstanding response is lost. Memory is reset by the same rst.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum {IDLE, WAIT_RESP} arb_state_t;
  - typedef enum {OWN_NONE, OWN_I, OWN_D} arb_owner_t;
  - a localparam for the full byte-enable value.
- Optional sub-module arb_streak_counter (saturating counter with clear, width $clog2(MAX_DSTREAK+1)). Everything else stays in one module.

Test Plan:
- Lone fetch: i_req=1, i_addr=0x100, m_gnt=1 in the same cycle, m_rvalid 2 cycles later with m_rdata=0x00000013. Expect i_gnt=1 in cycle 0, i_rvalid=1 with i_rdata=0x13, d_rvalid=0.
- Contention: i_req and d_req both held, memory always grants, rvalid 1 cycle after grant. Expect grant order D,D,D,D,I,D,D,D,D,I with MAX_DSTREAK=4.
- Wait-state lock: d_req with d_addr=0x200 and m_gnt held low 3 cycles; i_req asserted in cycle 1. Expect m_addr stable at 0x200 and no i_gnt until after D's response.
- Flush in flight: fetch granted at 0x300, i_flush pulsed 1 cycle before m_rvalid. Expect i_rvalid=0, FSM back to IDLE, and the next fetch at 0x400 returns normally.
- Flush same cycle as grant, and flush of a locked ungranted fetch. Expect no i_rvalid in either case; in the second, m_req drops that cycle and a waiting d_req is served next.
- Async reset asserted during WAIT_RESP. Expect all outputs 0 immediately, and after release a fresh d_req (write, d_be=4'b0011) is granted with m_we=1, m_be=4'b0011.
